// File: rtl/hpi_pkg.sv
// Shared definitions for the HPI host-port bus sequencer: FSM state
// encoding, HPI register address map and elaboration-time helpers.
package hpi_pkg;

  // Sequencer phases. CHIPRST is the only path that drives otg_rst_n low.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_STROBE  = 3'd2,
    ST_HOLD    = 3'd3,
    ST_RECOVER = 3'd4,
    ST_CHIPRST = 3'd5
  } hpi_state_e;

  // HPI register map as seen on otg_addr.
  localparam logic [1:0] HPI_REG_DATA    = 2'd0;
  localparam logic [1:0] HPI_REG_MAILBOX = 2'd1;
  localparam logic [1:0] HPI_REG_ADDRESS = 2'd2;
  localparam logic [1:0] HPI_REG_STATUS  = 2'd3;

  // Largest of the five phase lengths; sizes the shared down-counter.
  function automatic int max_cyc(input int a, input int b, input int c,
                                 input int d, input int e);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    return m;
  endfunction

  // Counter width able to hold (max_val - 1); never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    int w;
    w = 1;
    while ((1 << w) < max_val) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/hpi_bus_sequencer.sv
// HPI bus sequencer: turns single host register requests into timed
// CS/RD/WR strobe sequences on an HPI port, plus a chip-reset pulse.
// All pin-level outputs are registered; they are computed from the
// next state so each pin value lines up with the phase it belongs to.
module hpi_bus_sequencer
  import hpi_pkg::*;
#(
  parameter int SETUP_CYC    = 1,
  parameter int STROBE_CYC   = 2,
  parameter int HOLD_CYC     = 1,
  parameter int RECOVERY_CYC = 1,
  parameter int RST_CYC      = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_addr,
  input  logic [15:0] req_wdata,
  input  logic        rst_req,
  output logic        resp_valid,
  output logic [15:0] resp_rdata,
  output logic [1:0]  otg_addr,
  output logic        otg_cs_n,
  output logic        otg_rd_n,
  output logic        otg_wr_n,
  output logic        otg_rst_n,
  output logic [15:0] otg_dout,
  output logic        otg_doe,
  input  logic [15:0] otg_din
);

  localparam int MAX_CYC = max_cyc(SETUP_CYC, STROBE_CYC, HOLD_CYC,
                                   RECOVERY_CYC, RST_CYC);
  localparam int CNT_W   = cnt_width(MAX_CYC);

  typedef logic [CNT_W-1:0] cnt_t;

  // Counter reload values: a phase of N cycles counts N-1 down to 0.
  localparam cnt_t SETUP_LD = cnt_t'(SETUP_CYC - 1);
  localparam cnt_t STROBE_LD = cnt_t'(STROBE_CYC - 1);
  localparam cnt_t HOLD_LD = cnt_t'(HOLD_CYC - 1);
  localparam cnt_t RECOV_LD = cnt_t'(RECOVERY_CYC - 1);
  localparam cnt_t RST_LD = cnt_t'(RST_CYC - 1);
  localparam cnt_t CNT_ZERO = cnt_t'(0);
  localparam cnt_t CNT_ONE = cnt_t'(1);

  hpi_state_e  state_q, state_d;
  cnt_t        cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [1:0]  addr_q, addr_d;
  logic [15:0] dout_q, dout_d;
  logic [15:0] rdata_q, rdata_d;
  logic        cs_n_q, cs_n_d;
  logic        rd_n_q, rd_n_d;
  logic        wr_n_q, wr_n_d;
  logic        rst_n_q, rst_n_d;
  logic        doe_q, doe_d;
  logic        resp_valid_q, resp_valid_d;
  logic        accept_s;
  logic        capture_s;

  // A pending chip-reset request blocks the handshake in the same cycle,
  // so the host keeps its access until the reset pulse has finished.
  assign req_ready = (state_q == ST_IDLE) && !reset && !rst_req;

  assign otg_addr   = addr_q;
  assign otg_dout   = dout_q;
  assign otg_doe    = doe_q;
  assign otg_cs_n   = cs_n_q;
  assign otg_rd_n   = rd_n_q;
  assign otg_wr_n   = wr_n_q;
  assign otg_rst_n  = rst_n_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;

  // Next-state and phase-counter logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    accept_s  = 1'b0;
    capture_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rst_req) begin
          state_d = ST_CHIPRST;
          cnt_d   = RST_LD;
        end else if (req_valid && req_ready) begin
          accept_s = 1'b1;
          state_d  = ST_SETUP;
          cnt_d    = SETUP_LD;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
        end
      end
      ST_SETUP: begin
        if (cnt_q == CNT_ZERO) begin
          state_d = ST_STROBE;
          cnt_d   = STROBE_LD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_STROBE: begin
        if (cnt_q == CNT_ZERO) begin
          // Read data is taken on the edge that closes the strobe.
          capture_s = !write_q;
          state_d   = ST_HOLD;
          cnt_d     = HOLD_LD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_HOLD: begin
        if (cnt_q == CNT_ZERO) begin
          state_d = ST_RECOVER;
          cnt_d   = RECOV_LD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_RECOVER: begin
        if (cnt_q == CNT_ZERO) begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_CHIPRST: begin
        if (cnt_q == CNT_ZERO) begin
          state_d = ST_RECOVER;
          cnt_d   = RECOV_LD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Pin and response values for the cycle being entered (state_d).
  always_comb begin
    write_d      = write_q;
    addr_d       = addr_q;
    dout_d       = dout_q;
    rdata_d      = rdata_q;
    cs_n_d       = 1'b1;
    rd_n_d       = 1'b1;
    wr_n_d       = 1'b1;
    rst_n_d      = 1'b1;
    doe_d        = 1'b0;
    resp_valid_d = 1'b0;

    if (accept_s) begin
      write_d = req_write;
      addr_d  = req_addr;
      dout_d  = req_wdata;
    end else begin
      write_d = write_q;
    end

    if (capture_s) begin
      rdata_d = otg_din;
    end else begin
      rdata_d = rdata_q;
    end

    case (state_d)
      ST_SETUP: begin
        cs_n_d = 1'b0;
        doe_d  = write_d;
      end
      ST_STROBE: begin
        cs_n_d = 1'b0;
        rd_n_d = write_d;
        wr_n_d = !write_d;
        doe_d  = write_d;
      end
      ST_HOLD: begin
        cs_n_d       = 1'b0;
        doe_d        = write_d;
        // Only the STROBE->HOLD transition marks the first HOLD cycle.
        resp_valid_d = (state_q == ST_STROBE);
      end
      ST_CHIPRST: begin
        rst_n_d = 1'b0;
      end
      default: begin
        cs_n_d = 1'b1;
      end
    endcase
  end

  // State, counter and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= CNT_ZERO;
      write_q      <= 1'b0;
      addr_q       <= 2'd0;
      dout_q       <= 16'h0000;
      rdata_q      <= 16'h0000;
      cs_n_q       <= 1'b1;
      rd_n_q       <= 1'b1;
      wr_n_q       <= 1'b1;
      rst_n_q      <= 1'b1;
      doe_q        <= 1'b0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      dout_q       <= dout_d;
      rdata_q      <= rdata_d;
      cs_n_q       <= cs_n_d;
      rd_n_q       <= rd_n_d;
      wr_n_q       <= wr_n_d;
      rst_n_q      <= rst_n_d;
      doe_q        <= doe_d;
      resp_valid_q <= resp_valid_d;
    end
  end

endmodule

// File: tb/tb_hpi_bus_sequencer.sv
// Directed bench for hpi_bus_sequencer. Two instances share all inputs:
// "a" uses default timing, "b" uses SETUP=2 STROBE=3 HOLD=2 RECOVERY=2 RST=4.
// Per-cycle pin traces after the acceptance edge are packed into bit masks
// (bit k = cycle k after acceptance) and compared with hand-derived masks.
module tb_hpi_bus_sequencer;
  import hpi_pkg::*;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_addr;
  logic [15:0] req_wdata;
  logic        rst_req;
  logic [15:0] otg_din;

  logic        a_req_ready, a_resp_valid, a_cs_n, a_rd_n, a_wr_n, a_rst_n, a_doe;
  logic [15:0] a_resp_rdata, a_dout;
  logic [1:0]  a_addr;
  logic        b_req_ready, b_resp_valid, b_cs_n, b_rd_n, b_wr_n, b_rst_n, b_doe;
  logic [15:0] b_resp_rdata, b_dout;
  logic [1:0]  b_addr;

  int total;
  int bad;

  logic [31:0] a_cs_m, a_rd_m, a_wr_m, a_doe_m, a_rv_m, a_rdy_m, a_rst_m;
  logic [31:0] b_cs_m, b_rd_m, b_wr_m, b_doe_m, b_rv_m, b_rdy_m, b_rst_m;
  logic [1:0]  a_addr_t [0:31];
  logic [15:0] a_dout_t [0:31];
  logic [15:0] a_rdata_t [0:31];
  logic [15:0] b_rdata_t [0:31];

  hpi_bus_sequencer u_dut_a (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(a_req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rst_req(rst_req), .resp_valid(a_resp_valid), .resp_rdata(a_resp_rdata),
    .otg_addr(a_addr), .otg_cs_n(a_cs_n), .otg_rd_n(a_rd_n), .otg_wr_n(a_wr_n),
    .otg_rst_n(a_rst_n), .otg_dout(a_dout), .otg_doe(a_doe), .otg_din(otg_din)
  );

  hpi_bus_sequencer #(
    .SETUP_CYC(2), .STROBE_CYC(3), .HOLD_CYC(2), .RECOVERY_CYC(2), .RST_CYC(4)
  ) u_dut_b (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(b_req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rst_req(rst_req), .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata),
    .otg_addr(b_addr), .otg_cs_n(b_cs_n), .otg_rd_n(b_rd_n), .otg_wr_n(b_wr_n),
    .otg_rst_n(b_rst_n), .otg_dout(b_dout), .otg_doe(b_doe), .otg_din(otg_din)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for every check.
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Bus data pattern: mode 0 puts 0xBEEF on the default strobe cycles,
  // mode 1 tags every cycle with its index so capture timing is visible.
  function automatic logic [15:0] din_at(input int mode, input int k);
    if (mode == 0) return ((k == 2) || (k == 3)) ? 16'hBEEF : 16'h0F0F;
    return 16'hC000 | 16'(k);
  endfunction

  // Issue a request (optionally with rst_req), keep req_valid until
  // 'accepts' handshakes on instance a, and trace n cycles after the
  // first edge. Entered and left #1 after a rising edge.
  task automatic do_access(input logic wr, input logic [1:0] ad, input logic [15:0] wd,
                           input int mode, input int accepts, input logic rst, input int n);
    int acc_left;
    req_write = wr;
    req_addr  = ad;
    req_wdata = wd;
    req_valid = 1'b1;
    rst_req   = rst;
    otg_din   = din_at(mode, 0);
    acc_left  = accepts;
    @(negedge clk);
    check_eq("k0_ready", {31'd0, a_req_ready}, {31'd0, !rst});
    if (a_req_ready && req_valid) acc_left = acc_left - 1;
    @(posedge clk);
    #1;
    rst_req = 1'b0;
    if (acc_left == 0) req_valid = 1'b0;
    a_cs_m = 32'd0; a_rd_m = 32'd0; a_wr_m = 32'd0; a_doe_m = 32'd0;
    a_rv_m = 32'd0; a_rdy_m = 32'd0; a_rst_m = 32'd0;
    b_cs_m = 32'd0; b_rd_m = 32'd0; b_wr_m = 32'd0; b_doe_m = 32'd0;
    b_rv_m = 32'd0; b_rdy_m = 32'd0; b_rst_m = 32'd0;
    for (int k = 1; k <= n; k++) begin
      otg_din = din_at(mode, k);
      @(negedge clk);
      a_cs_m[k] = ~a_cs_n;   a_rd_m[k] = ~a_rd_n;  a_wr_m[k] = ~a_wr_n;
      a_doe_m[k] = a_doe;    a_rv_m[k] = a_resp_valid;
      a_rdy_m[k] = a_req_ready; a_rst_m[k] = ~a_rst_n;
      b_cs_m[k] = ~b_cs_n;   b_rd_m[k] = ~b_rd_n;  b_wr_m[k] = ~b_wr_n;
      b_doe_m[k] = b_doe;    b_rv_m[k] = b_resp_valid;
      b_rdy_m[k] = b_req_ready; b_rst_m[k] = ~b_rst_n;
      a_addr_t[k] = a_addr;  a_dout_t[k] = a_dout;
      a_rdata_t[k] = a_resp_rdata; b_rdata_t[k] = b_resp_rdata;
      if (a_req_ready && req_valid) acc_left = acc_left - 1;
      @(posedge clk);
      #1;
      if (acc_left == 0) req_valid = 1'b0;
    end
  endtask

  // Let both instances drain back to IDLE.
  task automatic settle();
    req_valid = 1'b0;
    rst_req   = 1'b0;
    repeat (24) @(posedge clk);
    #1;
  endtask

  // Time limit: report and stop if the sequence never completes.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rv_after;
    total = 0;
    bad = 0;
    reset = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr = 2'd0;
    req_wdata = 16'h0000;
    rst_req = 1'b0;
    otg_din = 16'h0000;

    // Reset values while reset is held; vector = {cs,rd,wr,rst,doe,rv,rdy}.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_pins_a", {25'd0, a_cs_n, a_rd_n, a_wr_n, a_rst_n, a_doe, a_resp_valid, a_req_ready}, 32'h78);
    check_eq("rst_pins_b", {25'd0, b_cs_n, b_rd_n, b_wr_n, b_rst_n, b_doe, b_resp_valid, b_req_ready}, 32'h78);
    check_eq("rst_data_a", {a_resp_rdata, a_dout}, 32'h0);
    check_eq("rst_addr_a", {30'd0, a_addr}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_eq("ready_after_rel", {30'd0, a_req_ready, b_req_ready}, 32'h3);
    @(posedge clk);
    #1;

    // Write ADDRESS=0x1234.
    do_access(1'b1, HPI_REG_ADDRESS, 16'h1234, 0, 1, 1'b0, 14);
    check_eq("wr_cs_a",   a_cs_m,  32'h1E);
    check_eq("wr_wr_a",   a_wr_m,  32'h0C);
    check_eq("wr_rd_a",   a_rd_m,  32'h0);
    check_eq("wr_doe_a",  a_doe_m, 32'h1E);
    check_eq("wr_rv_a",   a_rv_m,  32'h10);
    check_eq("wr_rdy_a",  a_rdy_m, 32'h7FC0);
    check_eq("wr_addr_a", {a_addr_t[1], a_addr_t[4]}, {28'd0, 4'b1010});
    check_eq("wr_dout_a", {a_dout_t[1], a_dout_t[4]}, 32'h12341234);
    check_eq("wr_rdata_a", {16'd0, a_rdata_t[14]}, 32'h0);
    check_eq("wr_cs_b",   b_cs_m,  32'hFE);
    check_eq("wr_wr_b",   b_wr_m,  32'h38);
    check_eq("wr_doe_b",  b_doe_m, 32'hFE);
    check_eq("wr_rv_b",   b_rv_m,  32'h40);
    check_eq("wr_rdy_b",  b_rdy_m, 32'h7C00);
    settle();

    // Read DATA with 0xBEEF on the default strobe cycles.
    do_access(1'b0, HPI_REG_DATA, 16'hFFFF, 0, 1, 1'b0, 14);
    check_eq("rd_rd_a",   a_rd_m,  32'h0C);
    check_eq("rd_wr_a",   a_wr_m,  32'h0);
    check_eq("rd_doe_a",  a_doe_m, 32'h0);
    check_eq("rd_rv_a",   a_rv_m,  32'h10);
    check_eq("rd_data_a", {a_rdata_t[3], a_rdata_t[4]}, 32'h0000BEEF);
    check_eq("rd_rd_b",   b_rd_m,  32'h38);
    check_eq("rd_cs_b",   b_cs_m,  32'hFE);
    check_eq("rd_doe_b",  b_doe_m, 32'h0);
    check_eq("rd_rv_b",   b_rv_m,  32'h40);
    check_eq("rd_data_b", {b_rdata_t[5], b_rdata_t[6]}, 32'h00000F0F);
    settle();

    // Read STATUS with cycle-indexed bus data: capture cycle is visible.
    do_access(1'b0, HPI_REG_STATUS, 16'h0000, 1, 1, 1'b0, 14);
    check_eq("rd2_addr_a", {30'd0, a_addr_t[2]}, 32'h3);
    check_eq("rd2_data_a", {a_rdata_t[3], a_rdata_t[4]}, 32'hBEEFC003);
    check_eq("rd2_data_b", {b_rdata_t[5], b_rdata_t[6]}, 32'h0F0FC005);
    settle();

    // Write MAILBOX: read data must be left alone.
    do_access(1'b1, HPI_REG_MAILBOX, 16'hA5C3, 1, 1, 1'b0, 14);
    check_eq("wr2_dout_a",  {16'd0, a_dout_t[2]}, 32'hA5C3);
    check_eq("wr2_addr_a",  {30'd0, a_addr_t[3]}, 32'h1);
    check_eq("wr2_rdata",   {a_rdata_t[14], b_rdata_t[14]}, 32'hC003C005);
    check_eq("wr2_wr_b",    b_wr_m, 32'h38);
    settle();

    // Back-to-back writes with req_valid held. cs_n stays high through
    // RECOVER plus the IDLE handshake cycle before the next SETUP.
    do_access(1'b1, HPI_REG_DATA, 16'h0F0F, 0, 2, 1'b0, 14);
    check_eq("b2b_cs_a",  a_cs_m,  32'h79E);
    check_eq("b2b_rdy_a", a_rdy_m, 32'h7040);
    check_eq("b2b_rv_a",  a_rv_m,  32'h410);
    settle();

    // rst_req and req_valid together: 16-cycle reset pulse, then the access.
    do_access(1'b1, HPI_REG_ADDRESS, 16'h0042, 0, 1, 1'b1, 30);
    check_eq("crst_rst_a", a_rst_m, 32'h0001FFFE);
    check_eq("crst_cs_a",  a_cs_m,  32'h00780000);
    check_eq("crst_wr_a",  a_wr_m,  32'h00300000);
    check_eq("crst_rv_a",  a_rv_m,  32'h00400000);
    check_eq("crst_rdy_a", a_rdy_m, 32'h7F040000);
    check_eq("crst_rst_b", b_rst_m, 32'h1E);
    settle();

    // Reset during the second strobe cycle of a write.
    req_write = 1'b1;
    req_addr  = HPI_REG_ADDRESS;
    req_wdata = 16'h5555;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("mid_wr_low", {31'd0, a_wr_n}, 32'h0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_eq("mid_pins_a", {25'd0, a_cs_n, a_rd_n, a_wr_n, a_rst_n, a_doe, a_resp_valid, a_req_ready}, 32'h79);
    check_eq("mid_data_a", {a_resp_rdata, a_dout}, 32'h0);
    check_eq("mid_addr_a", {30'd0, a_addr}, 32'h0);
    rv_after = 32'd0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      rv_after[k] = a_resp_valid;
    end
    check_eq("mid_no_rv", rv_after, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
